// File: rtl/sel_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sel_controller_if
//  Description : Button inputs and select/enable outputs of sel_controller.
//                The master drives the raw buttons; the slave (controller)
//                drives the registered selects.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sel_controller_if;
  logic       btnL;
  logic       btnR;
  logic       btnU;
  logic       btnD;
  logic       btnC;
  logic [1:0] mux_sel;
  logic [1:0] demux_sel;
  logic       enable;
  logic       sel_changed;

  modport master (
    output btnL, btnR, btnU, btnD, btnC,
    input  mux_sel, demux_sel, enable, sel_changed
  );

  modport slave (
    input  btnL, btnR, btnU, btnD, btnC,
    output mux_sel, demux_sel, enable, sel_changed
  );
endinterface
`default_nettype wire

// File: rtl/sel_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sel_controller
//  Description : Five push-buttons, each synchronized and debounced, whose
//                press events step/clear a mux select, a demux select and
//                toggle a shared enable. sel_changed pulses on any update.
//  Revision    : 1.0 - initial release
// ============================================================================
module sel_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  sel_controller_if.slave   bus
);

  localparam int unsigned        CNT_W   = 24;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned        NUM_BTN = 5;
  localparam int unsigned        BTN_L   = 0;
  localparam int unsigned        BTN_R   = 1;
  localparam int unsigned        BTN_U   = 2;
  localparam int unsigned        BTN_D   = 3;
  localparam int unsigned        BTN_C   = 4;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {bus.btnC, bus.btnD, bus.btnU, bus.btnR, bus.btnL};

  // One synchronizer + debouncer + rising-edge detector per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles the synchronized level disagrees with the
    // debounced level; any agreement restarts the count.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (s2_q != stable_q) begin
        if (cnt_q == CNT_MAX) begin
          stable_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Synchronizer, debounce state and edge history registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        stable_q <= 1'b0;
        prev_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q     <= btn_raw[i];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        prev_q   <= stable_q;
        cnt_q    <= cnt_d;
      end
    end

    // A press is the rising edge of the debounced level; releases are ignored.
    assign press[i] = stable_q & ~prev_q;
  end

  logic [1:0] mux_sel_q,   mux_sel_d;
  logic [1:0] demux_sel_q, demux_sel_d;
  logic       enable_q,    enable_d;
  logic       sel_changed_q, sel_changed_d;

  // Select/enable update: clear wins over increments, btnU merges with
  // btnL/btnR so each select moves by at most one, enable toggles freely.
  always_comb begin
    mux_sel_d   = mux_sel_q;
    demux_sel_d = demux_sel_q;
    enable_d    = enable_q;
    if (press[BTN_D]) begin
      mux_sel_d   = 2'd0;
      demux_sel_d = 2'd0;
    end else begin
      if (press[BTN_L] || press[BTN_U]) begin
        mux_sel_d = mux_sel_q + 2'd1;
      end
      if (press[BTN_R] || press[BTN_U]) begin
        demux_sel_d = demux_sel_q + 2'd1;
      end
    end
    if (press[BTN_C]) begin
      enable_d = ~enable_q;
    end
    sel_changed_d = (mux_sel_d != mux_sel_q) || (demux_sel_d != demux_sel_q) ||
                    (enable_d != enable_q);
  end

  // Output registers; sel_changed lands in the same cycle as the new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_sel_q     <= 2'd0;
      demux_sel_q   <= 2'd0;
      enable_q      <= 1'b0;
      sel_changed_q <= 1'b0;
    end else begin
      mux_sel_q     <= mux_sel_d;
      demux_sel_q   <= demux_sel_d;
      enable_q      <= enable_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  assign bus.mux_sel     = mux_sel_q;
  assign bus.demux_sel   = demux_sel_q;
  assign bus.enable      = enable_q;
  assign bus.sel_changed = sel_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_sel_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sel_controller
//  Description : Directed self-checking bench for sel_controller with
//                DEBOUNCE_CYCLES = 4 (press visible 7 edges after drive).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_controller;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;

  sel_controller_if bus ();

  sel_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    bus.btnL = b[0];
    bus.btnR = b[1];
    bus.btnU = b[2];
    bus.btnD = b[3];
    bus.btnC = b[4];
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] m, input logic [1:0] d,
                             input logic e, input logic c);
    check({tag, "_mux"},   {6'd0, bus.mux_sel},     {6'd0, m});
    check({tag, "_demux"}, {6'd0, bus.demux_sel},   {6'd0, d});
    check({tag, "_en"},    {7'd0, bus.enable},      {7'd0, e});
    check({tag, "_chg"},   {7'd0, bus.sel_changed}, {7'd0, c});
  endtask

  // Drive buttons from the next edge; returns just after the edge where the
  // resulting update appears (edge 6 counting the first sampling edge as 0).
  task automatic press(input string tag, input logic [4:0] b);
    set_btns(b);
    tick(6);
    check({tag, "_early_chg"}, {7'd0, bus.sel_changed}, 8'd0);
    tick(1);
  endtask

  // Release all buttons, confirm the pulse lasted one cycle, let it settle.
  task automatic release_all(input string tag);
    set_btns(5'b0);
    tick(1);
    check({tag, "_pulse_len"}, {7'd0, bus.sel_changed}, 8'd0);
    tick(8);
    check({tag, "_idle_chg"}, {7'd0, bus.sel_changed}, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_btns(5'b0);
    do_reset();
    check_state("reset", 2'd0, 2'd0, 1'b0, 1'b0);

    // Held btnL: single step at edge 6, no repeat while held or on release.
    press("hold_l", B_L);
    check_state("hold_l", 2'd1, 2'd0, 1'b0, 1'b1);
    tick(1);
    check_state("hold_l_after", 2'd1, 2'd0, 1'b0, 1'b0);
    tick(12);
    check_state("hold_l_long", 2'd1, 2'd0, 1'b0, 1'b0);
    release_all("hold_l");
    check_state("hold_l_rel", 2'd1, 2'd0, 1'b0, 1'b0);

    do_reset();
    check_state("reset2", 2'd0, 2'd0, 1'b0, 1'b0);

    // Bounce: two-cycle high/low runs never reach the debounce threshold.
    for (int i = 0; i < 40; i++) begin
      bus.btnL = ((i % 4) < 2);
      tick(1);
      check("bounce_mux", {6'd0, bus.mux_sel}, 8'd0);
      check("bounce_chg", {7'd0, bus.sel_changed}, 8'd0);
    end
    bus.btnL = 1'b0;
    tick(10);
    check_state("bounce_end", 2'd0, 2'd0, 1'b0, 1'b0);

    // Four btnR presses walk demux_sel through 1,2,3 and wrap to 0.
    press("r1", B_R); check_state("r1", 2'd0, 2'd1, 1'b0, 1'b1); release_all("r1");
    press("r2", B_R); check_state("r2", 2'd0, 2'd2, 1'b0, 1'b1); release_all("r2");
    press("r3", B_R); check_state("r3", 2'd0, 2'd3, 1'b0, 1'b1); release_all("r3");
    press("r4", B_R); check_state("r4", 2'd0, 2'd0, 1'b0, 1'b1); release_all("r4");

    // Set mux=2, demux=1, then U+D+C together: clear wins, enable toggles.
    press("l1", B_L); check_state("l1", 2'd1, 2'd0, 1'b0, 1'b1); release_all("l1");
    press("l2", B_L); check_state("l2", 2'd2, 2'd0, 1'b0, 1'b1); release_all("l2");
    press("r5", B_R); check_state("r5", 2'd2, 2'd1, 1'b0, 1'b1); release_all("r5");
    press("udc", B_U | B_D | B_C);
    check_state("udc", 2'd0, 2'd0, 1'b1, 1'b1);
    release_all("udc");

    // Clear with selects already zero and no enable toggle: no pulse.
    press("d_noop", B_D);
    check_state("d_noop", 2'd0, 2'd0, 1'b1, 1'b0);
    release_all("d_noop");

    // Combined presses: each select steps exactly once.
    press("lu", B_L | B_U);        check_state("lu", 2'd1, 2'd1, 1'b1, 1'b1);  release_all("lu");
    press("ru", B_R | B_U);        check_state("ru", 2'd2, 2'd2, 1'b1, 1'b1);  release_all("ru");
    press("lru", B_L | B_R | B_U); check_state("lru", 2'd3, 2'd3, 1'b1, 1'b1); release_all("lru");
    press("u_wrap", B_U);          check_state("u_wrap", 2'd0, 2'd0, 1'b1, 1'b1); release_all("u_wrap");
    press("l_only", B_L);          check_state("l_only", 2'd1, 2'd0, 1'b1, 1'b1); release_all("l_only");

    // Reset two cycles into a btnC debounce; held button debounces afresh.
    bus.btnC = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    check_state("mid_rst", 2'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(6);
    check_state("post_rst_pre", 2'd0, 2'd0, 1'b0, 1'b0);
    tick(1);
    check_state("post_rst_c", 2'd0, 2'd0, 1'b1, 1'b1);
    release_all("post_rst_c");

    // btnC alone toggles enable back off.
    press("c_off", B_C);
    check_state("c_off", 2'd0, 2'd0, 1'b0, 1'b1);
    release_all("c_off");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
